// File: rtl/rsa_modexp_core.sv
// Modular exponentiation core: RES = M^E mod N, left-to-right square-and-multiply
// on top of a bit-serial interleaved modular multiplier (one multiplier bit per cycle).
module rsa_modexp_core #(
    parameter int WIDTH  = 256,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         we,
    input  logic [1:0]                   reg_sel,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [7:0]                   wdata,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [7:0]                   rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [$clog2(WIDTH+1)-1:0]   ebits
);
    localparam int NB   = WIDTH / 8;
    localparam int EB_W = $clog2(WIDTH + 1);
    localparam int IW   = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SQR,
        S_MUL,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d, e_q, e_d, n_q, n_d;
    logic [WIDTH-1:0]  wm_q, wm_d, ew_q, ew_d, wn_q, wn_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              err_q, err_d, done_q, done_d;
    logic [EB_W-1:0]   ebits_q, ebits_d;
    logic [IW-1:0]     idx_q, idx_d, cnt_q, cnt_d;
    logic [WIDTH+1:0]  p_q, p_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;

    logic [EB_W-1:0]   ebit_len;
    logic [WIDTH+1:0]  n_ext, addend, p_acc, p_s1, p_next;
    logic [WIDTH-1:0]  r_new;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        e_d      = e_q;
        n_d      = n_q;
        wm_d     = wm_q;
        ew_d     = ew_q;
        wn_d     = wn_q;
        res_d    = res_q;
        err_d    = err_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        a_d      = a_q;
        b_d      = b_q;

        ebit_len = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (e_q[k]) ebit_len = EB_W'(k + 1);
        end
        ebits_d = ebit_len;

        // One modmul step: shift-and-add, then at most two conditional subtractions.
        n_ext  = {2'b00, wn_q};
        addend = a_q[WIDTH-1] ? {2'b00, b_q} : '0;
        p_acc  = (p_q << 1) + addend;
        p_s1   = (p_acc >= n_ext) ? (p_acc - n_ext) : p_acc;
        p_next = (p_s1 >= n_ext) ? (p_s1 - n_ext) : p_s1;
        r_new  = p_next[WIDTH-1:0];

        if (we && state_q == S_IDLE) begin
            for (int k = 0; k < NB; k++) begin
                if (addr == ADDR_W'(k)) begin
                    case (reg_sel)
                        2'd1:    m_d[8*k +: 8] = wdata;
                        2'd2:    e_d[8*k +: 8] = wdata;
                        2'd3:    n_d[8*k +: 8] = wdata;
                        default: ;
                    endcase
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                wm_d  = m_q;
                ew_d  = e_q;
                wn_d  = n_q;
                p_d   = '0;
                cnt_d = '0;
                a_d   = WIDTH'(1);
                b_d   = WIDTH'(1);
                if (n_q < WIDTH'(2) || m_q >= n_q) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (ebit_len == '0) begin
                    res_d   = WIDTH'(1);
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d   = IW'(ebit_len - EB_W'(1));
                    state_d = S_SQR;
                end
            end
            S_SQR, S_MUL: begin
                p_d   = p_next;
                a_d   = a_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IW'(WIDTH - 1)) begin
                    p_d   = '0;
                    cnt_d = '0;
                    if (state_q == S_SQR && ew_q[idx_q]) begin
                        state_d = S_MUL;
                        a_d     = r_new;
                        b_d     = wm_q;
                    end else if (idx_q == '0) begin
                        state_d = S_DONE;
                        res_d   = r_new;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQR;
                        a_d     = r_new;
                        b_d     = r_new;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            wm_q    <= '0;
            ew_q    <= '0;
            wn_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ebits_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            e_q     <= e_d;
            n_q     <= n_d;
            wm_q    <= wm_d;
            ew_q    <= ew_d;
            wn_q    <= wn_d;
            res_q   <= res_d;
            err_q   <= err_d;
            done_q  <= done_d;
            ebits_q <= ebits_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NB; k++) begin
            if (rd_addr == ADDR_W'(k)) rdata = res_q[8*k +: 8];
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = done_q;
    assign err   = err_q;
    assign ebits = ebits_q;

endmodule
